// File: rtl/arb_pkg.sv
// Shared types for the dual-core memory arbiter: FSM encoding, core id, access record.
package arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  typedef logic core_id_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  we;
    logic [DATA_W_DEF-1:0] wdata;
  } acc_rec_t;

  function automatic core_id_t other_core(input core_id_t c);
    return ~c;
  endfunction

endpackage

// File: rtl/dual_core_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: pointer core wins a tie, otherwise the lone requester wins.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  core_id_t   pointer_i,
  output core_id_t   winner_o,
  output logic       any_o
);

  always_comb begin
    any_o    = |eligible_i;
    winner_o = (&eligible_i) ? pointer_i : core_id_t'(eligible_i[1]);
  end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two cores, one access per cycle.
// Define ARB_LOCK_EN to add per-core lock inputs that hold the bus for atomic read-modify-write.
module dual_core_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core0_req,
  input  logic [ADDR_W-1:0] core0_addr,
  input  logic              core0_we,
  input  logic [DATA_W-1:0] core0_wdata,
`ifdef ARB_LOCK_EN
  input  logic              core0_lock,
  input  logic              core1_lock,
`endif
  output logic              core0_gnt,
  output logic              core0_valid,
  output logic [DATA_W-1:0] core0_rdata,
  input  logic              core1_req,
  input  logic [ADDR_W-1:0] core1_addr,
  input  logic              core1_we,
  input  logic [DATA_W-1:0] core1_wdata,
  output logic              core1_gnt,
  output logic              core1_valid,
  output logic [DATA_W-1:0] core1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } rec_t;

  arb_state_e              state_q, state_d;
  core_id_t                ptr_q, ptr_d, owner_q, win;
  logic [1:0]              gnt_q, valid_q, req, elig;
  logic                    act_q, any;
  rec_t                    bus_q;
  rec_t                    rec [2];
  logic [1:0][DATA_W-1:0]  rdata_q;

  always_comb begin
    req    = {core1_req, core0_req};
    rec[0] = '{addr: core0_addr, we: core0_we, wdata: core0_wdata};
    rec[1] = '{addr: core1_addr, we: core1_we, wdata: core1_wdata};
    // a core whose grant is showing is still dropping req and must not issue twice
    elig   = req & ~gnt_q;
`ifdef ARB_LOCK_EN
    if (state_q == ST_LOCKED) elig = elig & (owner_q ? 2'b10 : 2'b01);
`endif
  end

  rr_pick2 u_pick (
    .eligible_i (elig),
    .pointer_i  (ptr_q),
    .winner_o   (win),
    .any_o      (any)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any) state_d = ST_ACCESS;
      ST_ACCESS: if (!any) state_d = ST_IDLE;
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_IDLE;
    endcase
`ifdef ARB_LOCK_EN
    if (any) begin
      if (win) state_d = core1_lock ? ST_LOCKED : ST_ACCESS;
      else     state_d = core0_lock ? ST_LOCKED : ST_ACCESS;
    end
`endif
    ptr_d = any ? other_core(win) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= RESET_PRIO;
      gnt_q   <= '0;
      act_q   <= 1'b0;
      owner_q <= 1'b0;
      bus_q   <= '0;
      valid_q <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= '0;
      act_q <= any;
      if (any) begin
        gnt_q[win] <= 1'b1;
        owner_q    <= win;
        bus_q      <= rec[win];
      end else begin
        bus_q.we   <= 1'b0;
      end
      valid_q <= '0;
      if (act_q) begin
        valid_q[owner_q] <= 1'b1;
        rdata_q[owner_q] <= mem_rdata;
      end
    end
  end

  always_comb begin
    core0_gnt   = gnt_q[0];
    core1_gnt   = gnt_q[1];
    core0_valid = valid_q[0];
    core1_valid = valid_q[1];
    core0_rdata = rdata_q[0];
    core1_rdata = rdata_q[1];
    mem_addr    = bus_q.addr;
    mem_we      = bus_q.we;
    mem_wdata   = bus_q.wdata;
  end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Bench for dual_core_mem_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_dual_core_mem_arbiter;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       core0_req, core0_we, core1_req, core1_we;
  logic [7:0] core0_addr, core0_wdata, core1_addr, core1_wdata;
  logic       core0_gnt, core0_valid, core1_gnt, core1_valid;
  logic [7:0] core0_rdata, core1_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
`ifdef ARB_LOCK_EN
  logic       core0_lock, core1_lock;
`endif

  logic [7:0] mem [256];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  dual_core_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RESET_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .core0_req(core0_req), .core0_addr(core0_addr), .core0_we(core0_we), .core0_wdata(core0_wdata),
`ifdef ARB_LOCK_EN
    .core0_lock(core0_lock), .core1_lock(core1_lock),
`endif
    .core0_gnt(core0_gnt), .core0_valid(core0_valid), .core0_rdata(core0_rdata),
    .core1_req(core1_req), .core1_addr(core1_addr), .core1_we(core1_we), .core1_wdata(core1_wdata),
    .core1_gnt(core1_gnt), .core1_valid(core1_valid), .core1_rdata(core1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory refills with a known pattern during reset; preload overrides single cells
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 256; i++) mem[i] <= 8'((i * 7) + 3);
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core0_req = 0; core0_we = 0; core0_addr = 0; core0_wdata = 0;
    core1_req = 0; core1_we = 0; core1_addr = 0; core1_wdata = 0;
`ifdef ARB_LOCK_EN
    core0_lock = 0; core1_lock = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) step();
    reset = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    step();
    pl_en = 0;
  endtask

  task automatic test_reset();
    core0_req = 1; core0_we = 1; core0_addr = 8'hFF; core0_wdata = 8'h5A;
    step();
    do_reset();
    n_cmp++; if ({core0_gnt, core0_valid, core1_gnt, core1_valid, mem_we} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctl got %b want 00000", {core0_gnt, core0_valid, core1_gnt, core1_valid, mem_we});
    end
    n_cmp++; if ({core0_rdata, core1_rdata, mem_addr, mem_wdata} !== 32'h0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {core0_rdata, core1_rdata, mem_addr, mem_wdata});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    preload(8'd12, 8'hB4);
    core0_req = 1; core0_addr = 8'd12; core0_we = 0;
    step();
    n_cmp++; if ({core0_gnt, core0_valid, core1_gnt, mem_we} !== 4'b1000 || mem_addr !== 8'd12) begin
      n_err++; $display("FAIL rd_edge1 got gnt0=%b v0=%b gnt1=%b we=%b addr=%0d want 1,0,0,0,12",
                        core0_gnt, core0_valid, core1_gnt, mem_we, mem_addr);
    end
    core0_req = 0;
    step();
    n_cmp++; if (core0_valid !== 1'b1 || core0_rdata !== 8'hB4 || core0_gnt !== 1'b0) begin
      n_err++; $display("FAIL rd_edge2 got v0=%b rdata=%h gnt0=%b want 1,b4,0", core0_valid, core0_rdata, core0_gnt);
    end
    n_cmp++; if ({core1_gnt, core1_valid} !== 2'b00 || core1_rdata !== 8'h00) begin
      n_err++; $display("FAIL rd_core1_quiet got gnt1=%b v1=%b rdata1=%h want 0,0,00", core1_gnt, core1_valid, core1_rdata);
    end
    step();
    n_cmp++; if (core0_valid !== 1'b0 || core0_rdata !== 8'hB4) begin
      n_err++; $display("FAIL rd_hold got v0=%b rdata=%h want 0,b4", core0_valid, core0_rdata);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] dat [2];
    dat[0] = 8'hA0; dat[1] = 8'hA1;
    do_reset();
    preload(8'd0, dat[0]);
    preload(8'd1, dat[1]);
    core0_req = 1; core0_addr = 8'd0;
    core1_req = 1; core1_addr = 8'd1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 4) begin
        n_cmp++; if ({core1_gnt, core0_gnt} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin
          n_err++; $display("FAIL alt_gnt edge=%0d got %b%b want core%0d", k, core1_gnt, core0_gnt, (k % 2 == 1) ? 0 : 1);
        end
      end
      if (k >= 2) begin
        int o;
        o = ((k - 1) % 2 == 1) ? 0 : 1;
        n_cmp++; if ({core1_valid, core0_valid} !== (o == 0 ? 2'b01 : 2'b10) ||
                     (o == 0 ? core0_rdata : core1_rdata) !== dat[o]) begin
          n_err++; $display("FAIL alt_valid edge=%0d got v=%b%b r0=%h r1=%h want core%0d data %h",
                            k, core1_valid, core0_valid, core0_rdata, core1_rdata, o, dat[o]);
        end
      end
      if (k == 4) begin core0_req = 0; core1_req = 0; end
    end
  endtask

  task automatic test_write_read();
    int we_cnt = 0;
    do_reset();
    core1_req = 1; core1_we = 1; core1_addr = 8'd40; core1_wdata = 8'h55;
    step(); we_cnt += int'(mem_we);
    n_cmp++; if (core1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd40 || mem_wdata !== 8'h55) begin
      n_err++; $display("FAIL wr_issue got gnt1=%b we=%b addr=%0d wdata=%h want 1,1,40,55", core1_gnt, mem_we, mem_addr, mem_wdata);
    end
    core1_we = 0;
    step(); we_cnt += int'(mem_we);
    n_cmp++; if (core1_valid !== 1'b1 || core1_gnt !== 1'b0 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL wr_ack got v1=%b gnt1=%b we=%b want 1,0,0", core1_valid, core1_gnt, mem_we);
    end
    step(); we_cnt += int'(mem_we);
    n_cmp++; if (core1_gnt !== 1'b1 || mem_addr !== 8'd40) begin
      n_err++; $display("FAIL rd_issue got gnt1=%b addr=%0d want 1,40", core1_gnt, mem_addr);
    end
    core1_req = 0;
    step(); we_cnt += int'(mem_we);
    n_cmp++; if (core1_valid !== 1'b1 || core1_rdata !== 8'h55) begin
      n_err++; $display("FAIL rd_back got v1=%b rdata=%h want 1,55", core1_valid, core1_rdata);
    end
    repeat (2) begin step(); we_cnt += int'(mem_we); end
    n_cmp++; if (we_cnt !== 1) begin
      n_err++; $display("FAIL we_once got %0d cycles want 1", we_cnt);
    end
  endtask

  task automatic test_hold_req();
    int g = 0, v = 0;
    do_reset();
    core0_req = 1; core0_addr = 8'd7;
    for (int k = 1; k <= 5; k++) begin
      step();
      g += int'(core0_gnt);
      v += int'(core0_valid);
      if (k == 2) core0_req = 0;
    end
    n_cmp++; if (g !== 1 || v !== 1) begin
      n_err++; $display("FAIL hold_req got gnts=%0d valids=%0d want 1,1", g, v);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    core0_req = 1; core0_we = 1; core0_addr = 8'd9; core0_wdata = 8'h33;
    step();
    core0_req = 0; core0_we = 0;
    reset = 1;
    step();
    n_cmp++; if ({core0_valid, core0_gnt, mem_we} !== 3'b000) begin
      n_err++; $display("FAIL rst_inflight got v0=%b gnt0=%b we=%b want 0,0,0", core0_valid, core0_gnt, mem_we);
    end
    reset = 0;
    core0_req = 1; core0_addr = 8'd3; core1_req = 1; core1_addr = 8'd4;
    step();
    n_cmp++; if ({core1_gnt, core0_gnt} !== 2'b01) begin
      n_err++; $display("FAIL rst_prio got %b%b want 01", core1_gnt, core0_gnt);
    end
    idle_inputs();
    repeat (2) step();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    core0_req = 1; core0_lock = 1; core0_addr = 8'd50; core0_we = 0;
    core1_req = 1; core1_addr = 8'd60;
    step();
    n_cmp++; if ({core1_gnt, core0_gnt} !== 2'b01) begin
      n_err++; $display("FAIL lock_grant got %b%b want 01", core1_gnt, core0_gnt);
    end
    core0_req = 0; core0_lock = 0;
    step();
    n_cmp++; if (core1_gnt !== 1'b0 || core0_valid !== 1'b1) begin
      n_err++; $display("FAIL lock_block got gnt1=%b v0=%b want 0,1", core1_gnt, core0_valid);
    end
    core0_req = 1; core0_we = 1; core0_wdata = 8'h77;
    step();
    n_cmp++; if ({core1_gnt, core0_gnt} !== 2'b01 || mem_we !== 1'b1) begin
      n_err++; $display("FAIL lock_unlock got %b%b we=%b want 01,1", core1_gnt, core0_gnt, mem_we);
    end
    core0_req = 0; core0_we = 0;
    step();
    n_cmp++; if (core1_gnt !== 1'b1) begin
      n_err++; $display("FAIL lock_release got gnt1=%b want 1", core1_gnt);
    end
    idle_inputs();
    repeat (2) step();
  endtask
`endif

  // Random traffic from two protocol-following cores, scored against a transaction-level model.
  task automatic test_random();
    acc_rec_t   rq [2];
    logic [1:0] treq, e_gnt, e_valid, e_rd, elig;
    logic [7:0] refmem [256];
    logic [7:0] e_rdata [2];
    logic [7:0] e_addr, e_wdata;
    logic       e_we, pref, w, p_act, p_owner;
    acc_rec_t   p_rec;
    do_reset();
    for (int i = 0; i < 256; i++) refmem[i] = 8'((i * 7) + 3);
    treq = 0; e_gnt = 0; e_valid = 0; e_rd = 0; e_addr = 0; e_wdata = 0; e_we = 0;
    pref = 1'b0; p_act = 0; p_owner = 0; p_rec = '0; w = 0;
    e_rdata[0] = 0; e_rdata[1] = 0; rq[0] = '0; rq[1] = '0;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) begin
        n_cmp++; if ({core1_gnt, core0_gnt} !== e_gnt || {core1_valid, core0_valid} !== e_valid) begin
          n_err++; $display("FAIL rnd_ctl cyc=%0d got gnt=%b%b v=%b%b want gnt=%b v=%b",
                            k, core1_gnt, core0_gnt, core1_valid, core0_valid, e_gnt, e_valid);
        end
        n_cmp++; if (mem_we !== e_we || mem_addr !== e_addr || (e_we && mem_wdata !== e_wdata)) begin
          n_err++; $display("FAIL rnd_bus cyc=%0d got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                            k, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
        end
        if (e_valid[0] && e_rd[0]) begin
          n_cmp++; if (core0_rdata !== e_rdata[0]) begin
            n_err++; $display("FAIL rnd_rd0 cyc=%0d got %h want %h", k, core0_rdata, e_rdata[0]);
          end
        end
        if (e_valid[1] && e_rd[1]) begin
          n_cmp++; if (core1_rdata !== e_rdata[1]) begin
            n_err++; $display("FAIL rnd_rd1 cyc=%0d got %h want %h", k, core1_rdata, e_rdata[1]);
          end
        end
      end
      // cores: hold a request until its grant, then either stop or start another
      for (int i = 0; i < 2; i++) begin
        if (!treq[i] || e_gnt[i]) begin
          treq[i] = ($urandom_range(1, 0) == 1);
          case ($urandom_range(7, 0))
            0:       rq[i].addr = 8'd0;
            1:       rq[i].addr = 8'd255;
            default: rq[i].addr = 8'($urandom_range(255, 0));
          endcase
          rq[i].we    = ($urandom_range(2, 0) == 0);
          rq[i].wdata = 8'($urandom_range(255, 0));
        end
      end
      core0_req = treq[0]; core0_addr = rq[0].addr; core0_we = rq[0].we; core0_wdata = rq[0].wdata;
      core1_req = treq[1]; core1_addr = rq[1].addr; core1_we = rq[1].we; core1_wdata = rq[1].wdata;
      // reference: finish the access on the bus, then choose the next one
      elig = treq & ~e_gnt;
      e_valid = 0; e_rd = 0;
      if (p_act) begin
        e_valid[p_owner] = 1'b1;
        e_rd[p_owner] = !p_rec.we;
        if (p_rec.we) refmem[p_rec.addr] = p_rec.wdata;
        else          e_rdata[p_owner] = refmem[p_rec.addr];
      end
      if (elig != 2'b00) begin
        w = (elig == 2'b11) ? pref : elig[1];
        pref = !w;
        e_gnt = w ? 2'b10 : 2'b01;
        e_addr = rq[w].addr; e_we = rq[w].we; e_wdata = rq[w].wdata;
        p_act = 1; p_owner = w; p_rec = rq[w];
      end else begin
        e_gnt = 0; e_we = 0; p_act = 0;
      end
      step();
    end
    idle_inputs();
    repeat (2) step();
  endtask

  initial begin
    reset = 1; pl_en = 0; pl_addr = 0; pl_data = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_hold_req();
    test_reset_inflight();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_core_mem_arbiter.md
Name: dual_core_mem_arbiter

Overview:
Arbitrates one single-port 8-bit memory between the two cores of the 2-core build, covering program fetches and LD_MEM / LD_MEM_REG data accesses.
- Each core issues a request/grant access; the arbiter registers the winner onto the shared memory bus.
- The read result returns to the owning core one cycle later.
- Sits between the core fetch/load units and the shared memory, whose read is combinational (data = mem[addr]).

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
RESET_PRIO, 0, core holding priority after reset (0 or 1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
core0_req  input  1  core 0 access request; held until core0_gnt seen
core0_addr  input  ADDR_W  core 0 address, stable while req high
core0_we  input  1  core 0 write enable (1 = write)
core0_wdata  input  DATA_W  core 0 write data
core0_gnt  output  1  one-cycle pulse: core 0 request accepted
core0_valid  output  1  one-cycle pulse: core 0 access completed
core0_rdata  output  DATA_W  core 0 read data, qualified by core0_valid
core1_req / core1_addr / core1_we / core1_wdata / core1_gnt / core1_valid / core1_rdata  same as core 0, for core 1
mem_addr  output  ADDR_W  shared memory address
mem_we  output  1  shared memory write strobe
mem_wdata  output  DATA_W  shared memory write data
mem_rdata  input  DATA_W  shared memory combinational read data

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM=IDLE, priority pointer=RESET_PRIO. In-flight access is dropped: no valid, no write strobe in the following cycle.
- Eligible request: coreN_req=1 AND coreN_gnt=0 in the same cycle. This prevents a double issue while the core drops req.
- Cycle t, eligible requests sampled:
  - one eligible: it wins.
  - both eligible: the pointer core wins, then the pointer moves to the other core.
  - single winner: pointer moves to the non-winner.
- Edge end of t, winner w:
  - mem_addr/mem_we/mem_wdata <= core w fields.
  - coreW_gnt <= 1; owner <= w; FSM <= ACCESS.
- Cycle t+1:
  - memory driven; coreW_rdata <= mem_rdata; coreW_valid <= 1 at edge end of t+1.
  - Latency from req sample to valid: 2 edges. valid pulses for writes too (ack); rdata is meaningful only for reads.
- mem_we is high exactly one cycle per granted write; 0 otherwise.
- Pipelined: a new grant may issue at edge end of t+1 while valid for t returns. Throughput is one access per cycle.
- FSM states:
  - IDLE: no access on the bus.
  - ACCESS: bus carries the granted access.
  - LOCKED: only with the optional feature.
- FSM transitions:
  - IDLE->ACCESS on any eligible request.
  - ACCESS->ACCESS on a new winner.
  - ACCESS->IDLE when there is no eligible request; mem_we is then forced 0 and mem_addr holds its last value.
- Non-winning core's gnt/valid stay 0. rdata of a core holds its last value until that core's next valid.
- Address wrap: none inside the arbiter; addresses pass through unchanged (255 stays 255).

Optional Feature:
ARB_LOCK_EN:
- Adds inputs core0_lock and core1_lock, sampled with req.
- A granted access with lock=1 moves the FSM to LOCKED(owner). Only the owner is eligible until the owner issues a granted access with lock=0, which returns the FSM to ACCESS.
- This gives atomic read-modify-write.
- Reset clears LOCKED.
- Without the macro: no lock ports, no LOCKED state, pure round-robin.

Decomposition:
- Package arb_pkg:
  - ADDR_W/DATA_W defaults.
  - state encoding typedef (IDLE, ACCESS, LOCKED).
  - core-id typedef (1 bit).
  - access-record struct {addr, we, wdata}.
- Sub-module rr_pick2: combinational two-way round-robin picker. Inputs: eligible[1:0], pointer. Outputs: winner, any.

Test Plan:
- Reset, then core0 read addr 8'd12 with mem[12]=8'hB4 -> core0_gnt at edge 1, core0_valid=1 with rdata=8'hB4 at edge 2; core1 outputs 0.
- Both cores request every cycle after reset (RESET_PRIO=0), addrs 8'd0/8'd1 -> grants alternate 0,1,0,1; four valids, each with the correct owner's data.
- Core1 writes 8'h55 to addr 8'd40, then reads it -> mem_we high exactly one cycle; read valid returns 8'h55.
- Core0 holds req through its gnt cycle -> exactly one grant and one mem access issued.
- Reset asserted in the cycle after a grant -> no valid pulse, mem_we=0, pointer back to RESET_PRIO.
- (ARB_LOCK_EN) core0 lock read addr 8'd50 while core1 requests -> core1 blocked until core0's unlocked write, then core1 is granted the next cycle.
